axi4_burst_master: RTL and testbench
====================================

// Module: axi4_burst_master
// PURPOSE
//  AXI4 initiator: turns one command (read or write burst) into AW/W/B or AR/R traffic for memory-mapped AXI4 slaves (e.g. axi4 memory slave).
//  Used by DMA/test engines as the bus-side front end. One outstanding transaction at a time; INCR bursts only.
//  Write data streams in on wr_*, read data streams out on rd_*, completion reported on done/done_resp.
// PARAMETERS
//  DATA_WIDTH  32  AXI data width (bits); byte lanes = DATA_WIDTH/8
//  ADDR_WIDTH  16  AXI address width (bits)
// PORTS
//  ACLK       in   1           clock
//  ARESETn    in   1           reset. One clock; reset is synchronous and active-low.
//  cmd_valid  in   1           command offered
//  cmd_ready  out  1           command accepted when cmd_valid&&cmd_ready
//  cmd_write  in   1           1=write burst, 0=read burst
//  cmd_addr   in   ADDR_WIDTH  start byte address
//  cmd_len    in   8           beats-1 (AXI LEN)
//  cmd_size   in   3           bytes/beat = 1<<cmd_size (AXI SIZE)
//  wr_data    in   DATA_WIDTH  write beat data
//  wr_valid   in   1           write beat available
//  wr_ready   out  1           write beat consumed
//  rd_data    out  DATA_WIDTH  read beat data (=RDATA)
//  rd_valid   out  1           read beat valid (=RVALID in R_DATA)
//  rd_last    out  1           final read beat (=RLAST)
//  rd_ready   in   1           sink ready; drives RREADY
//  done       out  1           1-cycle pulse at transaction end
//  done_resp  out  2           worst response of transaction (00 OKAY, 10 SLVERR); valid with done
//  AWADDR/AWLEN/AWSIZE/AWVALID out, AWREADY in   AXI write address channel
//  WDATA/WVALID/WLAST out, WREADY in             AXI write data channel
//  BRESP[1:0]/BVALID in, BREADY out              AXI write response channel
//  ARADDR/ARLEN/ARSIZE/ARVALID out, ARREADY in   AXI read address channel
//  RDATA/RRESP[1:0]/RVALID/RLAST in, RREADY out  AXI read data channel
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; AWVALID=ARVALID=WVALID=WLAST=BREADY=RREADY=0; done=0; done_resp=00; A*ADDR/A*LEN/A*SIZE=0; beat_cnt=0.
//  Reset mid-operation: abandons burst at next edge, no done pulse; slave resync is the slave's responsibility.
//  FSM: IDLE -> AW_ADDR -> W_DATA -> B_RESP -> DONE | IDLE -> AR_ADDR -> R_DATA -> DONE; DONE -> IDLE after 1 cycle.
//  IDLE: cmd_ready=1; on accept latch addr/len/size/write into regs, cmd_ready<=0, AWVALID or ARVALID<=1 next cycle.
//  AW_ADDR/AR_ADDR: A*VALID held high, A* fields stable, until A*READY sampled high; then A*VALID<=0.
//  W_DATA: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY (combinational, only in W_DATA); WLAST=(beat_cnt==len_q).
//   beat_cnt++ on WVALID&&WREADY; last beat handshake -> B_RESP, beat_cnt<=0.
//  B_RESP: BREADY=1; on BVALID capture BRESP into resp_q -> DONE.
//  R_DATA: RREADY=rd_ready; rd_* pass-through; each RVALID&&RREADY: beat_cnt++, resp_q |= RRESP (sticky SLVERR).
//   End on handshake with RLAST=1. If beat count at RLAST != len_q+1, resp_q forced to 10. RLAST never seen: stays in R_DATA.
//  DONE: done=1, done_resp=resp_q for exactly one cycle; resp_q cleared on return to IDLE.
//  Illegal size: cmd_size > $clog2(DATA_WIDTH/8) -> no bus activity, DONE next cycle with done_resp=10.
//  Widths: beat_cnt 9 bits (len 255 -> 256 beats, no wrap); address not incremented by master (slave computes beats).
//  Latency: cmd accept -> A*VALID 1 cycle; last B/R handshake -> done 1 cycle.
// CONFIGURATION
//  AXI4_MASTER_4K_CHECK_EN defined: at accept, if (addr&12'hFFF)+((len+1)<<size) > 12'h1000, burst crosses 4KB ->
//   no AW/AR issued, DONE next cycle, done_resp=10, write data not consumed.
//  Undefined: command issued unchanged; error reported only via slave BRESP/RRESP.
// STRUCTURE
//  Package axi4_master_pkg: state enum typedef, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, AXI_4K_BYTES=4096.
//  Single module; no sub-module warranted (counter + FSM inline).
// TESTING  (against axi4 memory slave, DATA_WIDTH=32, MEMORY_DEPTH=1024)
//  Write addr 0x0010 len 3 size 2, data A0..A3 -> 4 W beats, WLAST on 4th only, BRESP 00, done_resp 00.
//  Read addr 0x0010 len 3 size 2 -> rd_data A0,A1,A2,A3, rd_last on 4th, done_resp 00.
//  Read addr 0x1000 len 0 -> RRESP 10, done_resp 10; WVALID never asserted.
//  Read len 7 with rd_ready toggling every cycle -> 8 beats in order, no lost/duplicated beat, done once.
//  Write addr 0x0FF8 len 3 size 2: with AXI4_MASTER_4K_CHECK_EN -> no AWVALID, done_resp 10; without -> BRESP 10.
//  ARESETn low after 2 of 4 write beats -> next edge AWVALID=WVALID=BREADY=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/axi4_master_pkg.sv
// rtl/axi4_master_pkg.sv - shared state encoding and AXI response constants for axi4_burst_master
package axi4_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_ADDR,
    ST_W_DATA,
    ST_B_RESP,
    ST_AR_ADDR,
    ST_R_DATA,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         AXI_4K_BYTES = 4096;

endpackage

// File: rtl/axi4_burst_master.sv
// rtl/axi4_burst_master.sv - single-outstanding AXI4 INCR burst initiator; AXI4_MASTER_4K_CHECK_EN rejects 4KB-crossing bursts
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [8:0]              beat_cnt;
  logic [1:0]              resp_q;
  logic                    size_bad, cross_4k, reject;
  logic                    w_hs, r_hs, w_last;

  assign size_bad = (cmd_size > MAX_SIZE);

`ifdef AXI4_MASTER_4K_CHECK_EN
  logic [19:0] span_end;
  assign span_end = {8'b0, cmd_addr[11:0]} + ({11'b0, {1'b0, cmd_len} + 9'd1} << cmd_size);
  assign cross_4k = (span_end > 20'(AXI_4K_BYTES));
`else
  assign cross_4k = 1'b0;
`endif

  // Rejected commands skip the bus entirely and report SLVERR through DONE.
  assign reject = size_bad | cross_4k;
  assign w_last = (beat_cnt == {1'b0, len_q});
  assign w_hs   = (state == ST_W_DATA) && wr_valid && WREADY;
  assign r_hs   = (state == ST_R_DATA) && RVALID && rd_ready;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = reject ? ST_DONE : (cmd_write ? ST_AW_ADDR : ST_AR_ADDR);
      ST_AW_ADDR: if (AWREADY) state_nxt = ST_W_DATA;
      ST_W_DATA:  if (w_hs && w_last) state_nxt = ST_B_RESP;
      ST_B_RESP:  if (BVALID) state_nxt = ST_DONE;
      ST_AR_ADDR: if (ARREADY) state_nxt = ST_R_DATA;
      ST_R_DATA:  if (r_hs && RLAST) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = RESP_OKAY;
    case (state)
      ST_IDLE:    cmd_ready = 1'b1;
      ST_AW_ADDR: AWVALID = 1'b1;
      ST_AR_ADDR: ARVALID = 1'b1;
      ST_W_DATA: begin
        WVALID   = wr_valid;
        WLAST    = w_last;
        wr_ready = WREADY;
      end
      ST_B_RESP:  BREADY = 1'b1;
      ST_R_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_last  = RLAST;
      end
      ST_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
      end
      default: ;
    endcase
  end

  assign AWADDR  = addr_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;
  assign WDATA   = wr_data;
  assign rd_data = RDATA;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      beat_cnt <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid) begin
          addr_q <= cmd_addr;
          len_q  <= cmd_len;
          size_q <= cmd_size;
          resp_q <= reject ? RESP_SLVERR : RESP_OKAY;
        end
        ST_W_DATA: if (w_hs) beat_cnt <= w_last ? 9'd0 : beat_cnt + 9'd1;
        ST_B_RESP: if (BVALID) resp_q <= BRESP;
        ST_R_DATA: if (r_hs) begin
          // A short or long burst (RLAST off the expected beat) is reported as SLVERR.
          if (RLAST) begin
            beat_cnt <= 9'd0;
            resp_q   <= (beat_cnt != {1'b0, len_q}) ? RESP_SLVERR : (resp_q | RRESP);
          end else begin
            beat_cnt <= beat_cnt + 9'd1;
            resp_q   <= resp_q | RRESP;
          end
        end
        ST_DONE: resp_q <= RESP_OKAY;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb/tb_axi4_burst_master.sv - directed self-checking bench for axi4_burst_master acting as the AXI slave
module tb_axi4_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic        WVALID, WLAST, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RVALID, RLAST, RREADY;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [0:1023];

  axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic offer_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_size = size;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [31:0] base, input logic [1:0] bresp, input logic [1:0] exp_resp, input string tag);
    int idx;
    offer_cmd(1'b1, addr, len, size);
    vectors++; if (AWVALID !== 1'b1 || cmd_ready !== 1'b0 || ARVALID !== 1'b0) begin miscompares++; $display("FAIL %s aw_issue: awvalid %b cmd_ready %b arvalid %b want 1 0 0", tag, AWVALID, cmd_ready, ARVALID); end
    vectors++; if (AWADDR !== addr || AWLEN !== len || AWSIZE !== size) begin miscompares++; $display("FAIL %s aw_fields: got %h/%h/%h want %h/%h/%h", tag, AWADDR, AWLEN, AWSIZE, addr, len, size); end
    tick();
    vectors++; if (AWVALID !== 1'b1 || AWADDR !== addr) begin miscompares++; $display("FAIL %s aw_hold: awvalid %b addr %h want 1 %h", tag, AWVALID, AWADDR, addr); end
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    vectors++; if (AWVALID !== 1'b0) begin miscompares++; $display("FAIL %s aw_drop: got %b want 0", tag, AWVALID); end
    for (int i = 0; i <= int'(len); i++) begin
      wr_valid = 1'b1; wr_data = base + 32'(i);
      if (i == 1) begin
        WREADY = 1'b0;
        #1;
        vectors++; if (WVALID !== 1'b1 || wr_ready !== 1'b0 || WLAST !== (i == int'(len))) begin miscompares++; $display("FAIL %s w_stall: wvalid %b wr_ready %b wlast %b", tag, WVALID, wr_ready, WLAST); end
        tick();
      end
      WREADY = 1'b1;
      #1;
      vectors++; if (WVALID !== 1'b1 || wr_ready !== 1'b1 || WDATA !== base + 32'(i)) begin miscompares++; $display("FAIL %s w_beat%0d: wvalid %b wr_ready %b wdata %h want 1 1 %h", tag, i, WVALID, wr_ready, WDATA, base + 32'(i)); end
      vectors++; if (WLAST !== (i == int'(len))) begin miscompares++; $display("FAIL %s wlast%0d: got %b want %b", tag, i, WLAST, (i == int'(len))); end
      idx = int'(addr >> 2) + i;
      if (idx < 1024) mem[idx] = base + 32'(i);
      tick();
    end
    WREADY = 1'b0;
    #1;
    vectors++; if (BREADY !== 1'b1 || WVALID !== 1'b0 || wr_ready !== 1'b0) begin miscompares++; $display("FAIL %s b_wait: bready %b wvalid %b wr_ready %b want 1 0 0", tag, BREADY, WVALID, wr_ready); end
    wr_valid = 1'b0;
    BVALID = 1'b1; BRESP = bresp;
    tick();
    BVALID = 1'b0; BRESP = 2'b00;
    vectors++; if (done !== 1'b1 || done_resp !== exp_resp) begin miscompares++; $display("FAIL %s done: done %b resp %b want 1 %b", tag, done, done_resp, exp_resp); end
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1 || done_resp !== 2'b00) begin miscompares++; $display("FAIL %s after_done: done %b cmd_ready %b resp %b want 0 1 00", tag, done, cmd_ready, done_resp); end
  endtask

  task automatic run_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size, input bit toggle,
                          input int rlast_at, input int bad_beat, input logic [1:0] exp_resp, input string tag);
    int k, cycles, idx;
    bit fin;
    logic [31:0] d;
    offer_cmd(1'b0, addr, len, size);
    vectors++; if (ARVALID !== 1'b1 || AWVALID !== 1'b0 || ARADDR !== addr || ARLEN !== len || ARSIZE !== size) begin miscompares++; $display("FAIL %s ar_issue: arvalid %b awvalid %b %h/%h/%h want 1 0 %h/%h/%h", tag, ARVALID, AWVALID, ARADDR, ARLEN, ARSIZE, addr, len, size); end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    vectors++; if (ARVALID !== 1'b0) begin miscompares++; $display("FAIL %s ar_drop: got %b want 0", tag, ARVALID); end
    k = 0; cycles = 0; fin = 1'b0;
    wr_valid = 1'b1;
    while (!fin && cycles < 64) begin
      idx = int'(addr >> 2) + k;
      d = (idx < 1024) ? mem[idx] : (32'hDEAD_0000 | 32'(k));
      RVALID = 1'b1; RDATA = d; RLAST = (k == rlast_at); RRESP = (k == bad_beat) ? 2'b10 : 2'b00;
      rd_ready = toggle ? cycles[0] : 1'b1;
      #1;
      vectors++; if (RREADY !== rd_ready || rd_valid !== 1'b1 || rd_last !== RLAST || WVALID !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL %s r_ctl%0d: rready %b rd_valid %b rd_last %b wvalid %b done %b", tag, k, RREADY, rd_valid, rd_last, WVALID, done); end
      if (rd_ready) begin
        vectors++; if (rd_data !== d) begin miscompares++; $display("FAIL %s rd_data%0d: got %h want %h", tag, k, rd_data, d); end
      end
      tick();
      if (rd_ready) begin
        if (k == rlast_at) fin = 1'b1;
        k++;
      end
      cycles++;
    end
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; rd_ready = 1'b0; wr_valid = 1'b0;
    vectors++; if (!fin) begin miscompares++; $display("FAIL %s r_timeout: got %0d beats want %0d", tag, k, rlast_at + 1); end
    vectors++; if (done !== 1'b1 || done_resp !== exp_resp) begin miscompares++; $display("FAIL %s done: done %b resp %b want 1 %b", tag, done, done_resp, exp_resp); end
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL %s after_done: done %b cmd_ready %b want 0 1", tag, done, cmd_ready); end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    tick(); tick();
    vectors++; if (cmd_ready !== 1'b1 || AWVALID !== 1'b0 || ARVALID !== 1'b0 || WVALID !== 1'b0 || WLAST !== 1'b0) begin miscompares++; $display("FAIL reset_ctl: cmd_ready %b awv %b arv %b wv %b wlast %b want 1 0 0 0 0", cmd_ready, AWVALID, ARVALID, WVALID, WLAST); end
    vectors++; if (BREADY !== 1'b0 || RREADY !== 1'b0 || done !== 1'b0 || done_resp !== 2'b00) begin miscompares++; $display("FAIL reset_resp: bready %b rready %b done %b resp %b want 0 0 0 00", BREADY, RREADY, done, done_resp); end
    vectors++; if (AWADDR !== 16'h0 || ARADDR !== 16'h0 || AWLEN !== 8'h0 || ARSIZE !== 3'h0) begin miscompares++; $display("FAIL reset_fields: awaddr %h araddr %h awlen %h arsize %h want 0", AWADDR, ARADDR, AWLEN, ARSIZE); end
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_illegal_size();
    wr_valid = 1'b1; wr_data = 32'h5555_5555;
    offer_cmd(1'b1, 16'h0020, 8'd1, 3'd3);
    #1;
    vectors++; if (AWVALID !== 1'b0 || ARVALID !== 1'b0 || wr_ready !== 1'b0) begin miscompares++; $display("FAIL bad_size_bus: awv %b arv %b wr_ready %b want 0 0 0", AWVALID, ARVALID, wr_ready); end
    vectors++; if (done !== 1'b1 || done_resp !== 2'b10) begin miscompares++; $display("FAIL bad_size_done: done %b resp %b want 1 10", done, done_resp); end
    wr_valid = 1'b0;
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL bad_size_after: done %b cmd_ready %b want 0 1", done, cmd_ready); end
  endtask

  task automatic test_4k_crossing();
`ifdef AXI4_MASTER_4K_CHECK_EN
    wr_valid = 1'b1; wr_data = 32'h7777_0000;
    offer_cmd(1'b1, 16'h0FF8, 8'd3, 3'd2);
    #1;
    vectors++; if (AWVALID !== 1'b0 || wr_ready !== 1'b0 || WVALID !== 1'b0) begin miscompares++; $display("FAIL cross4k_bus: awv %b wr_ready %b wvalid %b want 0 0 0", AWVALID, wr_ready, WVALID); end
    vectors++; if (done !== 1'b1 || done_resp !== 2'b10) begin miscompares++; $display("FAIL cross4k_done: done %b resp %b want 1 10", done, done_resp); end
    wr_valid = 1'b0;
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cross4k_after: done %b cmd_ready %b want 0 1", done, cmd_ready); end
`else
    run_write(16'h0FF8, 8'd3, 3'd2, 32'h7777_0000, 2'b10, 2'b10, "cross4k");
`endif
  endtask

  task automatic test_reset_mid_burst();
    offer_cmd(1'b1, 16'h0040, 8'd3, 3'd2);
    AWREADY = 1'b1;
    tick();
    AWREADY = 1'b0;
    wr_valid = 1'b1; wr_data = 32'hBEEF_0000; WREADY = 1'b1;
    tick(); tick();
    ARESETn = 1'b0;
    tick();
    vectors++; if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b0 || wr_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset_bus: awv %b wv %b bready %b wr_ready %b want 0 0 0 0", AWVALID, WVALID, BREADY, wr_ready); end
    vectors++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ctl: cmd_ready %b done %b want 1 0", cmd_ready, done); end
    ARESETn = 1'b1; wr_valid = 1'b0; WREADY = 1'b0;
    tick();
    vectors++; if (done !== 1'b0 || cmd_ready !== 1'b1 || WLAST !== 1'b0) begin miscompares++; $display("FAIL mid_reset_after: done %b cmd_ready %b wlast %b want 0 1 0", done, cmd_ready, WLAST); end
  endtask

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0; ARREADY = 1'b0;
    RDATA = '0; RRESP = 2'b00; RVALID = 1'b0; RLAST = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    @(negedge ACLK);

    test_reset();
    run_write(16'h0010, 8'd3, 3'd2, 32'h0000_00A0, 2'b00, 2'b00, "write_a0");
    run_read(16'h0010, 8'd3, 3'd2, 1'b0, 3, -1, 2'b00, "read_a0");
    run_read(16'h1000, 8'd0, 3'd2, 1'b0, 0, 0, 2'b10, "read_oob");
    run_read(16'h0100, 8'd7, 3'd2, 1'b1, 7, -1, 2'b00, "read_toggle");
    run_read(16'h0200, 8'd3, 3'd2, 1'b0, 1, -1, 2'b10, "read_short");
    run_read(16'h0300, 8'd3, 3'd2, 1'b0, 3, 2, 2'b10, "read_sticky");
    test_illegal_size();
    test_4k_crossing();
    test_reset_mid_burst();
    run_read(16'h0010, 8'd0, 3'd2, 1'b0, 0, -1, 2'b00, "read_recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
